// File: rtl/dm_arbiter.sv
// Data-memory arbiter: fixed-priority single-cycle CPU port plus a req/ack DMA word port.
// Define DM_ARB_STARVE_EN to build the DMA starvation guard (wait counter + forced grant with CPU stall).
module dm_arbiter #(
  parameter int DM_BYTES     = 12288,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [13:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [13:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [14:0] DM_LIMIT = 15'(DM_BYTES);

  state_t      state, state_nxt;
  logic        cpu_act;
  logic        grant;
  logic        force_grant;
  logic        in_range;
  logic [13:0] dma_base;
  logic [14:0] dma_last;
  logic        unused_addr_lsb;

`ifdef DM_ARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] wait_cnt, wait_cnt_nxt;
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
`endif

  assign cpu_act         = cpu_re | cpu_we;
  assign dma_base        = {dma_addr[13:2], 2'b00};
  assign dma_last        = {1'b0, dma_base} + 15'd3;
  assign in_range        = dma_last < DM_LIMIT;
  assign unused_addr_lsb = ^dma_addr[1:0];

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    force_grant = 1'b0;
`ifdef DM_ARB_STARVE_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (dma_req) begin
`ifdef DM_ARB_STARVE_EN
          force_grant = cpu_act && (wait_cnt == LIMIT);
`endif
          grant = !cpu_act || force_grant;
          if (grant) begin
            state_nxt = ACK;
`ifdef DM_ARB_STARVE_EN
            wait_cnt_nxt = 8'd0;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
`endif
          end
        end else begin
`ifdef DM_ARB_STARVE_EN
          wait_cnt_nxt = 8'd0;
`endif
        end
      end
      // ACK cycle: memory belongs to the CPU, a held dma_req is deliberately ignored
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A forced grant replaces the CPU access, so its store is dropped here and replayed by the stalled CPU
  assign dm_addr   = grant ? dma_base  : cpu_addr;
  assign dm_din    = grant ? dma_wdata : cpu_wdata;
  assign dm_we     = !rst && (grant ? (dma_we && in_range) : cpu_we);
  assign cpu_stall = !rst && force_grant;
  assign cpu_rdata = dm_dout;
  assign dma_ack   = (state == ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dma_rdata <= 32'd0;
      dma_err   <= 1'b0;
`ifdef DM_ARB_STARVE_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
`ifdef DM_ARB_STARVE_EN
      wait_cnt <= wait_cnt_nxt;
`endif
      if (grant) begin
        dma_rdata <= (dma_we || !in_range) ? 32'd0 : dm_dout;
        dma_err   <= !in_range;
      end
    end
  end

endmodule
